mem_port_arbiter: RTL and testbench

Two-requester memory arbiter that shares one downstream memory port between the CPU instruction-fetch port (port A) and data port (port B). It sits between the CPU and the unified cache/physical memory. It serialises transactions so that exactly one requester owns the downstream port from grant until the memory's `mem_resp`. It also keeps a conflict counter for performance analysis.

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch (A) and data (B).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is fixed B priority.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_a,
  input  logic        write_a,
  input  logic [1:0]  wmask_a,
  input  logic [15:0] address_a,
  input  logic [15:0] wdata_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_wmask,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic [15:0] conflict_count
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;  // 1 = B won most recently
  logic [15:0] cnt_q, cnt_nxt;
  logic        pend_a, pend_b, win_b;

  assign pend_a = read_a | write_a;
  assign pend_b = read_b | write_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign win_b = ~last_grant;
`else
  assign win_b = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt_q      <= 16'h0000;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_wmask      = 2'b00;
    mem_address    = 16'h0000;
    mem_wdata      = 16'h0000;
    resp_a         = 1'b0;
    resp_b         = 1'b0;
    case (state)
      IDLE: begin
        if (pend_a && pend_b) begin
          state_nxt      = win_b ? GRANT_B : GRANT_A;
          last_grant_nxt = win_b;
          if (cnt_q != 16'hFFFF) cnt_nxt = cnt_q + 16'd1;
        end else if (pend_a) begin
          state_nxt      = GRANT_A;
          last_grant_nxt = 1'b0;
        end else if (pend_b) begin
          state_nxt      = GRANT_B;
          last_grant_nxt = 1'b1;
        end
      end
      // Downstream follows the owner's live inputs; a read+write is a write.
      GRANT_A: begin
        mem_read    = read_a & ~write_a;
        mem_write   = write_a;
        mem_wmask   = wmask_a;
        mem_address = address_a;
        mem_wdata   = wdata_a;
        resp_a      = mem_resp;
        if (mem_resp) state_nxt = IDLE;
      end
      GRANT_B: begin
        mem_read    = read_b & ~write_b;
        mem_write   = write_b;
        mem_wmask   = wmask_b;
        mem_address = address_b;
        mem_wdata   = wdata_b;
        resp_b      = mem_resp;
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdata_a        = mem_rdata;
  assign rdata_b        = mem_rdata;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cases plus random traffic against a
// cycle-level reference of the arbitration rules; follows MEM_ARB_ROUND_ROBIN_EN like the DUT.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        read_a = 1'b0, write_a = 1'b0, read_b = 1'b0, write_b = 1'b0;
  logic [1:0]  wmask_a = 2'b00, wmask_b = 2'b00;
  logic [15:0] address_a = '0, wdata_a = '0, address_b = '0, wdata_b = '0;
  logic        resp_a, resp_b, mem_read, mem_write;
  logic [15:0] rdata_a, rdata_b, mem_address, mem_wdata, conflict_count;
  logic [1:0]  mem_wmask;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
    .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
    .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  typedef struct { int port; logic [35:0] bus; logic [15:0] cnt; } exp_t;
  exp_t        exp_q[$];
  int          served[$];
  int          m_owner = 0;
  int          m_last  = 1;
  logic [15:0] m_cnt   = '0;

  function automatic logic [35:0] port_bus(input int p);
    if (p == 0) return {read_a & ~write_a, write_a, wmask_a, address_a, wdata_a};
    return {read_b & ~write_b, write_b, wmask_b, address_b, wdata_b};
  endfunction

  always @(negedge clk) begin
    logic [35:0] ebus;
    logic        ea, eb;
    logic        pa, pb;
    int          win;
    if (reset) begin
      m_owner = 0; m_last = 1; m_cnt = '0;
      exp_q.delete();
    end else begin
      ebus = (m_owner == 0) ? 36'h0 : port_bus(m_owner - 1);
      ea   = (m_owner == 1) && mem_resp;
      eb   = (m_owner == 2) && mem_resp;
      chk("cycle",
          128'({mem_read, mem_write, mem_wmask, mem_address, mem_wdata, resp_a, resp_b,
                conflict_count, rdata_a, rdata_b}),
          128'({ebus, ea, eb, m_cnt, mem_rdata, mem_rdata}));
      if (m_owner != 0) begin
        if (mem_resp) m_owner = 0;
      end else begin
        pa = read_a | write_a;
        pb = read_b | write_b;
        if (pa || pb) begin
          if (pa && pb) begin
            win = RR ? 1 - m_last : 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          end else begin
            win = pb ? 1 : 0;
          end
          m_last  = win;
          m_owner = win + 1;
          exp_q.push_back('{win, port_bus(win), m_cnt});
        end
      end
    end
  end

  // Completion monitor: every resp must match the oldest predicted grant.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (resp_a || resp_b)) begin
      if (exp_q.size() == 0) begin
        chk("resp_without_grant", 128'({resp_a, resp_b}), 128'(2'b00));
      end else begin
        e = exp_q.pop_front();
        chk("txn",
            128'({resp_a, resp_b, mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
                  (resp_b ? rdata_b : rdata_a), conflict_count}),
            128'({e.port == 0, e.port == 1, e.bus, mem_rdata, e.cnt}));
        served.push_back(resp_b ? 1 : 0);
      end
    end
  end

  // Stimulus state: mode 0 manual, 1 random, 2 continuous (re-request until 4 served).
  int mode = 0, n_seen = 0, cont_base = 0, base = 0;
  int lat_fix = 1, cur_lat = 0, wait_cnt = 0;
  bit mem_en = 1'b1, rdata_fix_en = 1'b0;

  task automatic issue(input int p, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    if (p == 0) begin read_a = rd; write_a = wr; address_a = a; wdata_a = d; wmask_a = m; end
    else        begin read_b = rd; write_b = wr; address_b = a; wdata_b = d; wmask_b = m; end
  endtask

  task automatic drop(input int p);
    issue(p, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic issue_rand(input int p);
    logic [1:0] kind;
    kind = 2'($urandom_range(1, 3));
    issue(p, kind[0], kind[1], 16'($urandom), 16'($urandom), 2'($urandom));
  endtask

  task automatic step();
    int p;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    if (mem_en && (mem_read || mem_write)) begin
      if (wait_cnt == 0) cur_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      if (wait_cnt >= cur_lat) begin
        mem_resp  = 1'b1;
        mem_rdata = rdata_fix_en ? 16'hBEEF : 16'($urandom);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
    while (n_seen < served.size()) begin
      p = served[n_seen];
      n_seen++;
      drop(p);
      if (mode == 2 && served.size() - cont_base < 4) issue_rand(p);
    end
    if (mode == 1) begin
      if (!(read_a || write_a) && $urandom_range(0, 2) == 0) issue_rand(0);
      if (!(read_b || write_b) && $urandom_range(0, 2) == 0) issue_rand(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drop(0); drop(1);
    step();
    reset    = 1'b0;
    wait_cnt = 0;
    n_seen   = served.size();
  endtask

  task automatic wait_served(input int n, input int budget, input string name);
    int k = 0;
    while (served.size() < n && k < budget) begin step(); k++; end
    chk({name, "_timeout"}, 128'(served.size() >= n), 128'(1));
  endtask

  task automatic chk_order(input string name, input int first, input int want[5], input int n);
    for (int i = 0; i < n; i++)
      if (served.size() > first + i) chk(name, 128'(served[first + i]), 128'(want[i]));
  endtask

  initial begin
    int ord[5];
    int k;
    do_reset();
    chk("reset_count", 128'(conflict_count), 128'(0));

    // A read, memory answers 0xBEEF after 3 wait cycles
    lat_fix = 3; rdata_fix_en = 1'b1; base = served.size();
    issue(0, 1'b1, 1'b0, 16'h1000, 16'h0000, 2'b00);
    wait_served(base + 1, 40, "t1");
    ord = '{0, 0, 0, 0, 0};
    chk_order("t1_port", base, ord, 1);
    rdata_fix_en = 1'b0; lat_fix = 1;
    step();

    // B masked write
    base = served.size();
    issue(1, 1'b0, 1'b1, 16'h2002, 16'h1234, 2'b10);
    wait_served(base + 1, 40, "t2");
    ord = '{1, 0, 0, 0, 0};
    chk_order("t2_port", base, ord, 1);
    step();

    // Simultaneous requests right after reset
    do_reset();
    base = served.size();
    issue(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00);
    issue(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b00);
    wait_served(base + 2, 60, "t3");
    if (RR) ord = '{0, 1, 0, 0, 0}; else ord = '{1, 0, 0, 0, 0};
    chk_order("t3_order", base, ord, 2);
    chk("t3_count", 128'(conflict_count), 128'(1));
    step();

    // Both ports re-request continuously for four transactions
    do_reset();
    base = served.size(); cont_base = base; mode = 2; lat_fix = -1;
    issue_rand(0); issue_rand(1);
    wait_served(base + 5, 200, "t4");
    mode = 0;
    if (RR) ord = '{0, 1, 0, 1, 0}; else ord = '{1, 1, 1, 1, 0};
    chk_order("t4_order", base, ord, 5);
    chk("t4_count", 128'(conflict_count), 128'(4));
    step();

    // Reset during GRANT_A, stale mem_resp the cycle after
    mem_en = 1'b0;
    issue(0, 1'b1, 1'b0, 16'h3000, 16'h0000, 2'b00);
    k = 0;
    while (!mem_read && k < 10) begin step(); k++; end
    chk("t5_granted", 128'(mem_read), 128'(1));
    reset = 1'b1;
    drop(0);
    step();
    reset = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    chk("t5_resp", 128'({resp_a, resp_b}), 128'(2'b00));
    chk("t5_idle_bus", 128'({mem_read, mem_write}), 128'(2'b00));
    chk("t5_count", 128'(conflict_count), 128'(0));
    step();
    mem_en = 1'b1; wait_cnt = 0; n_seen = served.size();
    step();

    // Counter saturation from 0xFFFE
    force dut.cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step();
    release dut.cnt_q;
    for (int i = 0; i < 3; i++) begin
      base = served.size();
      issue_rand(0); issue_rand(1);
      wait_served(base + 2, 60, "t6");
      step();
    end
    chk("t6_saturate", 128'(conflict_count), 128'(16'hFFFF));

    // Random traffic, then drain
    mode = 1; lat_fix = -1;
    repeat (800) step();
    mode = 0;
    k = 0;
    while ((read_a || write_a || read_b || write_b) && k < 300) begin step(); k++; end
    chk("drain_pending", 128'({read_a, write_a, read_b, write_b}), 128'(0));
    repeat (2) step();
    chk("drain_queue", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
